// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N_CH valid/ready stream demultiplexer
// with one holding register per channel and a saturating drop counter.
module demux_stream #(
   parameter int N_CH  = 8,
   parameter int DW    = 1,
   parameter int CNT_W = 16,
   localparam int SELW = (N_CH > 2) ? $clog2(N_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DW-1:0]      s_data,
   input  logic [SELW-1:0]    s_sel,
   input  logic [N_CH-1:0]    ch_en,
   output logic [N_CH-1:0]    m_valid,
   input  logic [N_CH-1:0]    m_ready,
   output logic [N_CH*DW-1:0] m_data,
   output logic [CNT_W-1:0]   drop_cnt,
   output logic               drop_pulse
);

   logic [N_CH-1:0] hit;
   logic [N_CH-1:0] push;
   logic [N_CH-1:0] pop;
   logic            route_ok;
   logic            blocked;
   logic            drop;

   // out-of-range selects match no channel and fall through as drops
   always_comb begin
      hit      = '0;
      route_ok = 1'b0;
      blocked  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (s_sel == SELW'(i)) begin
            hit[i]   = 1'b1;
            route_ok = ch_en[i];
            blocked  = m_valid[i] & ~m_ready[i];
         end
      end
   end

   assign s_ready = ~route_ok | ~blocked;
   assign drop    = s_valid & ~route_ok;
   assign push    = hit & {N_CH{s_valid & s_ready & route_ok}};
   assign pop     = m_valid & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= '0;
      end else begin
         m_valid <= (m_valid & ~pop) | push;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
               m_data[i*DW +: DW] <= s_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop;
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: scenario tasks with per-channel queue scoreboard
// for demux_stream (8ch/8b main instance, 5ch/4b/2b-counter instance).
module tb_demux_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic [2:0]  s_sel;
   logic [7:0]  ch_en;
   logic [7:0]  m_valid;
   logic [7:0]  m_ready;
   logic [63:0] m_data;
   logic [15:0] drop_cnt;
   logic        drop_pulse;

   logic        b_s_valid;
   logic        b_s_ready;
   logic [3:0]  b_s_data;
   logic [2:0]  b_s_sel;
   logic [4:0]  b_ch_en;
   logic [4:0]  b_m_valid;
   logic [4:0]  b_m_ready;
   logic [19:0] b_m_data;
   logic [1:0]  b_drop_cnt;
   logic        b_drop_pulse;

   int checks = 0;
   int fails  = 0;
   int exp_drop = 0;
   logic [7:0] q [8][$];

   always #5 clk = ~clk;

   demux_stream #(.N_CH(8), .DW(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sel(s_sel),
      .ch_en(ch_en),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data),
      .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
   );

   demux_stream #(.N_CH(5), .DW(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .s_valid(b_s_valid), .s_ready(b_s_ready),
      .s_data(b_s_data), .s_sel(b_s_sel),
      .ch_en(b_ch_en),
      .m_valid(b_m_valid), .m_ready(b_m_ready),
      .m_data(b_m_data),
      .drop_cnt(b_drop_cnt), .drop_pulse(b_drop_pulse)
   );

   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b0; s_data = '0; s_sel = '0;
      ch_en = '1; m_ready = '0;
      b_s_valid = 1'b0; b_s_data = '0; b_s_sel = '0;
      b_ch_en = '1; b_m_ready = '1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 8'h00) begin
         fails++; $display("FAIL rst_mvalid got %h exp 00", m_valid);
      end
      checks++;
      if (m_data !== 64'h0) begin
         fails++; $display("FAIL rst_mdata got %h exp 0", m_data);
      end
      checks++;
      if (drop_cnt !== 16'h0) begin
         fails++; $display("FAIL rst_dropcnt got %h exp 0", drop_cnt);
      end
      checks++;
      if (drop_pulse !== 1'b0) begin
         fails++; $display("FAIL rst_pulse got %b exp 0", drop_pulse);
      end
      rst = 1'b0;
   endtask

   task automatic test_route();
      logic [7:0] e;
      ch_en = '1; m_ready = '1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i < 8) begin
            s_valid = 1'b1; s_sel = 3'(i); s_data = 8'(i & 1);
         end else begin
            s_valid = 1'b0;
         end
         #1;
         if (i > 0) begin
            e = q[i-1].pop_front();
            checks++;
            if (m_valid !== 8'(1 << (i-1))) begin
               fails++;
               $display("FAIL route_mvalid ch%0d got %h exp %h",
                        i-1, m_valid, 8'(1 << (i-1)));
            end
            checks++;
            if (m_data[(i-1)*8 +: 8] !== e) begin
               fails++;
               $display("FAIL route_data ch%0d got %h exp %h",
                        i-1, m_data[(i-1)*8 +: 8], e);
            end
         end
         if (i < 8) begin
            checks++;
            if (s_ready !== 1'b1) begin
               fails++; $display("FAIL route_sready ch%0d got 0 exp 1", i);
            end
            q[i].push_back(8'(i & 1));
         end
      end
   endtask

   task automatic test_hold();
      logic [7:0] e;
      m_ready = '1; m_ready[3] = 1'b0;
      @(negedge clk);
      s_valid = 1'b1; s_sel = 3'd3; s_data = 8'hA5;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         fails++; $display("FAIL hold_first_ready got 0 exp 1");
      end
      q[3].push_back(8'hA5);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         s_data = 8'h5A;
         #1;
         checks++;
         if (s_ready !== 1'b0) begin
            fails++; $display("FAIL hold_stall c%0d got 1 exp 0", k);
         end
         checks++;
         if (m_valid[3] !== 1'b1 || m_data[31:24] !== q[3][0]) begin
            fails++;
            $display("FAIL hold_stable c%0d got %b/%h exp 1/%h",
                     k, m_valid[3], m_data[31:24], q[3][0]);
         end
      end
      @(negedge clk);
      m_ready[3] = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         fails++; $display("FAIL hold_release got 0 exp 1");
      end
      e = q[3].pop_front();
      checks++;
      if (m_data[31:24] !== e) begin
         fails++; $display("FAIL hold_pop1 got %h exp %h", m_data[31:24], e);
      end
      q[3].push_back(8'h5A);
      @(negedge clk);
      s_valid = 1'b0; m_ready[3] = 1'b0;
      #1;
      checks++;
      if (m_valid[3] !== 1'b1 || m_data[31:24] !== q[3][0]) begin
         fails++;
         $display("FAIL hold_second got %b/%h exp 1/%h",
                  m_valid[3], m_data[31:24], q[3][0]);
      end
      @(negedge clk);
      m_ready[3] = 1'b1;
      #1;
      e = q[3].pop_front();
      checks++;
      if (m_data[31:24] !== e) begin
         fails++; $display("FAIL hold_pop2 got %h exp %h", m_data[31:24], e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 8'h00) begin
         fails++; $display("FAIL hold_drained got %h exp 00", m_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      m_ready = '1; ch_en = '1;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k < 10) begin
            s_valid = 1'b1; s_sel = 3'd3; s_data = 8'(8'h40 + k);
         end else begin
            s_valid = 1'b0;
         end
         #1;
         if (k > 0) begin
            e = q[3].pop_front();
            checks++;
            if (m_valid[3] !== 1'b1 || m_data[31:24] !== e) begin
               fails++;
               $display("FAIL b2b_pop%0d got %b/%h exp 1/%h",
                        k, m_valid[3], m_data[31:24], e);
            end
         end
         if (k < 10) begin
            checks++;
            if (s_ready !== 1'b1) begin
               fails++; $display("FAIL b2b_ready%0d got 0 exp 1", k);
            end
            q[3].push_back(8'(8'h40 + k));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 8'h00) begin
         fails++; $display("FAIL b2b_drained got %h exp 00", m_valid);
      end
   endtask

   task automatic test_drop();
      logic [7:0] e;
      @(negedge clk);
      ch_en = '1; ch_en[2] = 1'b0; m_ready = '1;
      s_valid = 1'b1; s_sel = 3'd2; s_data = 8'h33;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         fails++; $display("FAIL drop_ready got 0 exp 1");
      end
      exp_drop++;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if (drop_pulse !== 1'b1 || drop_cnt !== 16'(exp_drop)) begin
         fails++;
         $display("FAIL drop_count got %b/%0d exp 1/%0d",
                  drop_pulse, drop_cnt, exp_drop);
      end
      checks++;
      if (m_valid !== 8'h00) begin
         fails++; $display("FAIL drop_mvalid got %h exp 00", m_valid);
      end
      @(negedge clk);
      ch_en = '1; m_ready[2] = 1'b0;
      s_valid = 1'b1; s_data = 8'h77;
      #1;
      checks++;
      if (drop_pulse !== 1'b0) begin
         fails++; $display("FAIL drop_pulse_len got 1 exp 0");
      end
      q[2].push_back(8'h77);
      @(negedge clk);
      ch_en[2] = 1'b0; s_data = 8'h88;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         fails++; $display("FAIL drop_disabled_ready got 0 exp 1");
      end
      exp_drop++;
      @(negedge clk);
      s_valid = 1'b0; m_ready[2] = 1'b1;
      #1;
      e = q[2].pop_front();
      checks++;
      if (m_valid[2] !== 1'b1 || m_data[23:16] !== e) begin
         fails++;
         $display("FAIL drop_drain got %b/%h exp 1/%h",
                  m_valid[2], m_data[23:16], e);
      end
      checks++;
      if (drop_cnt !== 16'(exp_drop) || drop_pulse !== 1'b1) begin
         fails++;
         $display("FAIL drop_count2 got %0d/%b exp %0d/1",
                  drop_cnt, drop_pulse, exp_drop);
      end
      @(negedge clk);
      ch_en = '1;
      #1;
      checks++;
      if (m_valid !== 8'h00) begin
         fails++; $display("FAIL drop_drained got %h exp 00", m_valid);
      end
      b_s_sel = 3'd6; b_s_data = 4'h9;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         b_s_valid = 1'b1;
         #1;
         checks++;
         if (b_s_ready !== 1'b1 || b_m_valid !== 5'h0) begin
            fails++;
            $display("FAIL oor_k%0d got %b/%h exp 1/00",
                     k, b_s_ready, b_m_valid);
         end
         if (k == 1) begin
            checks++;
            if (b_drop_pulse !== 1'b1 || b_drop_cnt !== 2'd1) begin
               fails++;
               $display("FAIL oor_first got %b/%0d exp 1/1",
                        b_drop_pulse, b_drop_cnt);
            end
         end
      end
      @(negedge clk);
      b_s_valid = 1'b0;
      #1;
      checks++;
      if (b_drop_cnt !== 2'd3) begin
         fails++; $display("FAIL oor_sat got %0d exp 3", b_drop_cnt);
      end
      @(negedge clk);
      #1;
      checks++;
      if (b_drop_pulse !== 1'b0) begin
         fails++; $display("FAIL oor_pulse_off got 1 exp 0");
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      m_ready = '0; ch_en = '1;
      s_valid = 1'b1; s_sel = 3'd1; s_data = 8'h11;
      @(negedge clk);
      s_sel = 3'd4; s_data = 8'h44;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if (m_valid !== 8'h12) begin
         fails++; $display("FAIL mid_pre got %h exp 12", m_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (m_valid !== 8'h00 || drop_cnt !== 16'h0 || drop_pulse !== 1'b0) begin
         fails++;
         $display("FAIL mid_async got %h/%0d/%b exp 00/0/0",
                  m_valid, drop_cnt, drop_pulse);
      end
      for (int c = 0; c < 8; c++) q[c].delete();
      exp_drop = 0;
      @(negedge clk);
      rst = 1'b0; m_ready = '1;
      s_valid = 1'b1; s_sel = 3'd0; s_data = 8'h01;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         fails++; $display("FAIL mid_post_ready got 0 exp 1");
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if (m_valid !== 8'h01 || m_data[7:0] !== 8'h01) begin
         fails++;
         $display("FAIL mid_post got %h/%h exp 01/01", m_valid, m_data[7:0]);
      end
   endtask

   task automatic test_random();
      logic [7:0] mv;
      logic [7:0] e;
      logic       er;
      logic       last_drop;
      last_drop = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         if (n % 64 == 0) ch_en = 8'($urandom) | 8'($urandom);
         s_valid = ($urandom_range(0, 3) != 0);
         s_sel   = 3'($urandom);
         s_data  = 8'($urandom);
         m_ready = 8'($urandom);
         #1;
         for (int c = 0; c < 8; c++) mv[c] = (q[c].size() != 0);
         checks++;
         if (m_valid !== mv) begin
            fails++;
            $display("FAIL rnd_mvalid n%0d got %h exp %h", n, m_valid, mv);
         end
         checks++;
         if (drop_cnt !== 16'(exp_drop) || drop_pulse !== last_drop) begin
            fails++;
            $display("FAIL rnd_drop n%0d got %0d/%b exp %0d/%b",
                     n, drop_cnt, drop_pulse, exp_drop, last_drop);
         end
         for (int c = 0; c < 8; c++) begin
            if (mv[c] && m_ready[c]) begin
               e = q[c].pop_front();
               checks++;
               if (m_data[c*8 +: 8] !== e) begin
                  fails++;
                  $display("FAIL rnd_data n%0d ch%0d got %h exp %h",
                           n, c, m_data[c*8 +: 8], e);
               end
            end
         end
         er = !ch_en[s_sel] || !mv[s_sel] || m_ready[s_sel];
         checks++;
         if (s_ready !== er) begin
            fails++;
            $display("FAIL rnd_sready n%0d got %b exp %b", n, s_ready, er);
         end
         last_drop = s_valid && !ch_en[s_sel];
         if (last_drop && exp_drop < 65535) exp_drop++;
         if (s_valid && ch_en[s_sel] && er) q[s_sel].push_back(s_data);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_route();
      test_hold();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
